// File: rtl/dmem_access_unit_pkg.sv
// Shared RV32I types for the data-memory access stage.
// Holds funct3 encodings, access FSM states and access size decoding.
package rv32i_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } dmem_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } acc_size_t;

  // Unlisted store encodings act as words; loads key off funct3[1:0].
  function automatic acc_size_t acc_size(
    input logic [2:0] f3,
    input logic       is_store
  );
    acc_size_t sz;
    sz = SZ_W;
    if (is_store) begin
      unique case (store_funct3_t'(f3))
        SB:      sz = SZ_B;
        SH:      sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      unique case (f3[1:0])
        2'b00:   sz = SZ_B;
        2'b01:   sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/dmem_access_unit_align.sv
// Byte-lane alignment for dmem accesses.
// Builds write masks, shifts store data up and load data down.
import rv32i_types::*;

module dmem_align (
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_sh,
  output logic        misaligned
);

  acc_size_t  sz;
  logic [1:0] off;

  // Halves snap to the lower half-word, words to lane 0.
  always_comb begin
    sz         = acc_size(funct3, is_store);
    off        = offset;
    wmask      = 4'b1111;
    misaligned = 1'b0;
    unique case (sz)
      SZ_B: begin
        off   = offset;
        wmask = 4'b0001 << offset;
      end
      SZ_H: begin
        off        = {offset[1], 1'b0};
        wmask      = 4'b0011 << off;
        misaligned = offset[0];
      end
      default: begin
        off        = 2'b00;
        wmask      = 4'b1111;
        misaligned = |offset;
      end
    endcase
    wdata_sh = wdata << {off, 3'b000};
    rdata_sh = rdata_word >> {off, 3'b000};
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access stage: one load/store per request, dmem handshake.
// Define MISALIGN_TRAP_EN to fail misaligned half/word accesses without a bus cycle.
import rv32i_types::*;

module dmem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        access_err,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
);

  dmem_state_t state, state_nx;

  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        wr_q;
  logic        req_go;
  logic        tmo;
  logic        trap;
  logic [2:0]  a_f3;
  logic        a_st;
  logic [1:0]  a_off;
  logic [3:0]  mask;
  logic [31:0] wd_sh;
  logic [31:0] rd_sh;
  logic        mis;

  assign req_go = req_valid & (req_read | req_write);
  assign tmo    = (cnt == 8'(TIMEOUT_CYCLES - 1));

  assign a_f3  = (state == IDLE) ? funct3 : f3_q;
  assign a_st  = (state == IDLE) ? req_write : wr_q;
  assign a_off = (state == IDLE) ? addr[1:0] : off_q;

`ifdef MISALIGN_TRAP_EN
  assign trap = mis;
`else
  assign trap = mis & 1'b0;
`endif

  dmem_align u_align (
    .funct3     (a_f3),
    .is_store   (a_st),
    .offset     (a_off),
    .wdata      (wdata),
    .rdata_word (dmem_rdata),
    .wmask      (mask),
    .wdata_sh   (wd_sh),
    .rdata_sh   (rd_sh),
    .misaligned (mis)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, stall and done pulse.
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_go) begin
          stall    = 1'b1;
          state_nx = trap ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (dmem_resp || tmo) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, bus strobes, timeout counter and result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_read    <= 1'b0;
      dmem_write   <= 1'b0;
      dmem_wmask   <= 4'b0000;
      dmem_address <= 32'h0;
      dmem_wdata   <= 32'h0;
      rdata        <= 32'h0;
      access_err   <= 1'b0;
      cnt          <= 8'h0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      wr_q         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= 8'h0;
          if (req_go) begin
            f3_q         <= funct3;
            off_q        <= addr[1:0];
            wr_q         <= req_write;
            dmem_address <= {addr[31:2], 2'b00};
            if (trap) begin
              access_err <= 1'b1;
              rdata      <= 32'h0;
            end else begin
              dmem_read  <= ~req_write;
              dmem_write <= req_write;
              dmem_wmask <= req_write ? mask : 4'b0000;
              dmem_wdata <= wd_sh;
            end
          end
        end
        ACCESS: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            cnt        <= 8'h0;
            if (!wr_q) rdata <= rd_sh;
          end else if (tmo) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            access_err <= 1'b1;
            rdata      <= 32'h0;
            cnt        <= 8'h0;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        DONE: access_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Testbench for dmem_access_unit: directed cases plus random requests
// checked against a size/offset reference model and a scripted memory.
module tb_dmem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        access_err;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_resp = 1'b0;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_rdata = 32'h0;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_read     (req_read),
    .req_write    (req_write),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .done         (done),
    .rdata        (rdata),
    .access_err   (access_err),
    .dmem_address (dmem_address),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request from a negedge; memory answers during strobe cycle dly.
  task automatic xact(input string nm, input logic rd, input logic wr,
                      input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] word,
                      input int dly, input bit respond);
    int          nb, off, e_strb, e_stall;
    bit          mis, trap, e_err;
    logic [3:0]  e_mask;
    logic [31:0] e_wd, e_rd;
    int          stall_n = 0;
    int          strobe_n = 0;
    int          done_n = 0;
    bit          seen = 0;
    bit          fin = 0;
    logic [31:0] g_rd, g_addr, g_wd;
    logic [3:0]  g_mask;
    logic        g_err, g_r, g_w;

    if (wr) nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    else    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis = (int'(a[1:0]) % nb) != 0;
    off = (int'(a[1:0]) / nb) * nb;
`ifdef MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    e_mask = wr ? 4'(((1 << nb) - 1) << off) : 4'h0;
    e_wd   = wd << (8 * off);
    if (trap) begin
      e_strb = 0; e_stall = 1; e_err = 1; e_rd = 32'h0;
    end else if (respond && dly <= TO) begin
      e_strb = dly; e_stall = dly + 1; e_err = 0;
      e_rd = wr ? last_rdata : (word >> (8 * off));
    end else begin
      e_strb = TO; e_stall = TO + 1; e_err = 1; e_rd = 32'h0;
    end

    req_valid = 1'b1; req_read = rd; req_write = wr;
    funct3 = f3; addr = a; wdata = wd;
    dmem_rdata = word; dmem_resp = 1'b0;
    for (int c = 0; c < TO + 10 && !fin; c++) begin
      #1;
      if (stall) stall_n++;
      if (dmem_read | dmem_write) begin
        strobe_n++;
        if (!seen) begin
          seen = 1; g_addr = dmem_address; g_mask = dmem_wmask;
          g_wd = dmem_wdata; g_r = dmem_read; g_w = dmem_write;
        end
      end
      if (done) begin
        done_n++; g_rd = rdata; g_err = access_err; fin = 1;
        req_valid = 1'b0;
      end
      dmem_resp = respond && !fin && (dmem_read | dmem_write)
                  && (strobe_n == dly);
      @(negedge clk);
    end
    dmem_resp = 1'b0;
    req_valid = 1'b0;
    #1;
    check({nm, ".after_done"}, {29'h0, done, dmem_read, dmem_write}, 32'h0);
    check({nm, ".stall_n"}, stall_n, e_stall);
    check({nm, ".strobe_n"}, strobe_n, e_strb);
    check({nm, ".done_n"}, done_n, 1);
    check({nm, ".err"}, g_err, e_err);
    check({nm, ".rdata"}, g_rd, e_rd);
    if (seen) begin
      check({nm, ".addr"}, g_addr, {a[31:2], 2'b00});
      check({nm, ".kind"}, {g_r, g_w}, {rd & ~wr, wr});
      if (wr) begin
        check({nm, ".wmask"}, g_mask, e_mask);
        check({nm, ".wdata"}, g_wd, e_wd);
      end
    end
    last_rdata = e_rd;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst.strobes", {dmem_read, dmem_write}, 0);
    check("rst.wmask", dmem_wmask, 0);
    check("rst.rdata", rdata, 0);
    check("rst.done_err", {done, access_err}, 0);
    check("rst.stall", stall, 0);
    rst_n = 1'b1;
    @(negedge clk);

    xact("lw", 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, 1);
    xact("sb", 0, 1, 3'b000, 32'h203, 32'hA5, 32'h0, 1, 1);
    xact("lhu", 1, 0, 3'b101, 32'h302, 0, 32'h1234ABCD, 2, 1);
    xact("lb3", 1, 0, 3'b000, 32'h7, 0, 32'h89ABCDEF, 1, 1);
    xact("tmo", 1, 0, 3'b010, 32'h500, 0, 32'h55AA55AA, 0, 0);
    xact("resp_last", 1, 0, 3'b010, 32'h504, 0, 32'hCAFEF00D, TO, 1);
    xact("sw_mis", 0, 1, 3'b010, 32'h101, 32'h11223344, 0, 1, 1);
    xact("sh_mis", 0, 1, 3'b001, 32'h203, 32'h0000BEEF, 0, 2, 1);
    xact("rw_both", 1, 1, 3'b001, 32'h602, 32'h0000C0DE, 0, 1, 1);
    xact("st_f3_7", 0, 1, 3'b111, 32'h700, 32'h01020304, 0, 1, 1);

    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("noop", {stall, dmem_read, dmem_write, done}, 0);
      @(negedge clk);
    end
    req_valid = 1'b0;

    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
    funct3 = 3'b010; addr = 32'h400; dmem_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid.strobe", dmem_read, 1);
    rst_n = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; dmem_resp = 1'b1;
    #1;
    check("mid.after_rst", {dmem_read, dmem_write, done, stall}, 0);
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check("mid.late_resp", {dmem_read, dmem_write, done, access_err}, 0);
    check("mid.rdata", rdata, 0);
    last_rdata = 32'h0;
    @(negedge clk);
    xact("post_rst", 1, 0, 3'b010, 32'h404, 0, 32'h0BADF00D, 1, 1);

    for (int i = 0; i < 40; i++) begin
      logic rd, wr;
      wr = 1'($urandom);
      rd = wr ? 1'($urandom) : 1'b1;
      xact("rnd", rd, wr, 3'($urandom), $urandom, $urandom, $urandom,
           int'($urandom_range(1, TO + 1)), $urandom_range(0, 7) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
